// File: rtl/sequence_player.sv
// sequence_player
// ---------------------------------------------------------------------------
// Plays back a stored list of 2-bit colours, oldest first. Each colour is
// shown for ON_CYCLES clocks and followed by a dark gap of OFF_CYCLES clocks.
// A one-cycle done pulse marks the end of playback.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : synchronous, active-low reset
//   start        : playback request, honoured only in IDLE
//   length[5:0]  : number of colours to play (values above 32 count as 32)
//   segment      : colour store, [1] newest ... [N] oldest, [0] unused
//   abort        : (only with PLAYER_ABORT_EN) ends playback early
//   colour_out   : colour being shown, 2'b00 when dark
//   colour_valid : high while a colour is shown
//   busy         : high from the cycle after an accepted start through done
//   done         : one-cycle pulse at the end of playback
//
// Configuration
//   PLAYER_ABORT_EN : when defined, adds the abort input. abort=1 in ON or
//                     OFF jumps to DONE on the next cycle.
// ---------------------------------------------------------------------------
module sequence_player #(
    parameter int unsigned ON_CYCLES  = 25000000,
    parameter int unsigned OFF_CYCLES = 12500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       length,
    input  logic [32:0][1:0] segment,
`ifdef PLAYER_ABORT_EN
    input  logic             abort,
`endif
    output logic [1:0]       colour_out,
    output logic             colour_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [5:0]        index;
    logic [32:0][1:0]  snapshot;

    logic [5:0]        len_clamped;
    logic [5:0]        index_prev;
    logic              abort_req;

    assign len_clamped = (length > 6'd32) ? 6'd32 : length;
    assign index_prev  = index - 6'd1;

`ifdef PLAYER_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // NOTE: the snapshot is an ordinary register bank, not a RAM, so it is
    // reset to zero along with the rest of the state at no extra cost.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            index        <= '0;
            snapshot     <= '0;
            colour_out   <= 2'b00;
            colour_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees
            // the values from before this edge (e.g. snapshot is not yet
            // loaded on the accept edge, hence colour_out reads segment).
            case (state)
                IDLE: begin
                    if (start) begin
                        snapshot <= segment;
                        index    <= len_clamped;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        if (len_clamped == 6'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state        <= ON;
                            colour_valid <= 1'b1;
                            colour_out   <= segment[len_clamped];
                        end
                    end
                end

                ON: begin
                    if (abort_req) begin
                        state        <= DONE;
                        cnt          <= '0;
                        colour_valid <= 1'b0;
                        colour_out   <= 2'b00;
                        done         <= 1'b1;
                    end else if (cnt == ON_LAST) begin
                        state        <= OFF;
                        cnt          <= '0;
                        colour_valid <= 1'b0;
                        colour_out   <= 2'b00;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                OFF: begin
                    if (abort_req) begin
                        state <= DONE;
                        cnt   <= '0;
                        done  <= 1'b1;
                    end else if (cnt == OFF_LAST) begin
                        cnt <= '0;
                        if (index == 6'd1) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            // Walk towards the newest colour.
                            state        <= ON;
                            index        <= index_prev;
                            colour_valid <= 1'b1;
                            colour_out   <= snapshot[index_prev];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
